// File: rtl/systolic_pkg.sv
// Shared state encoding and arithmetic helpers for the systolic engine.
// Saturation helper is used when SYSTOLIC_SATURATE_EN is defined.
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DRAIN  = 3'd2,
    S_OUTPUT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int SAT_W = 128;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] val;
  } sat_res_t;

  function automatic int drain_steps(input int n);
    return 2 * n - 2;
  endfunction

  // Operands arrive sign-extended to SAT_W; w is the target width.
  function automatic sat_res_t sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      w
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                res;
    s  = a + b;
    hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    lo = ~hi;
    res.sat = 1'b0;
    res.val = s;
    if (s > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (s < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/systolic_skew_sr.sv
// Step-enabled delay line that skews one array edge input.
// DEPTH of zero collapses to a plain wire.
module systolic_skew_sr
  import systolic_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = &{1'b0, clock, reset_n, shift};
    assign dout = din;
  end else begin : g_sr
    logic [WIDTH-1:0] r_sr [DEPTH];
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else if (shift) begin
        r_sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
    end
    assign dout = r_sr[DEPTH-1];
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary N x N systolic matrix multiply (C = A*B or C += A*B).
// Define SYSTOLIC_SATURATE_EN for clamping accumulators and sat_flag.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_WIDTH    = 10
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [K_WIDTH-1:0]        k_len,
  input  logic                      acc_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DATA_WIDTH-1:0]   a_vec,
  input  logic [N*DATA_WIDTH-1:0]   b_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*ACC_WIDTH-1:0]    out_row,
  output logic [$clog2(N)-1:0]      out_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      sat_flag
);

  localparam int DW      = DATA_WIDTH;
  localparam int IDX_W   = $clog2(N);
  localparam int DRAIN_N = drain_steps(N);
  localparam int DC_W    = $clog2(DRAIN_N + 1);

  localparam logic [DC_W-1:0]  DRAIN_LAST = DC_W'(DRAIN_N - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);

  state_t             r_state;
  logic [K_WIDTH-1:0] r_klen;
  logic [K_WIDTH-1:0] r_cnt;
  logic [DC_W-1:0]    r_dcnt;
  logic [IDX_W-1:0]   r_idx;

  logic w_go;
  logic w_clr;
  logic w_step;

  logic signed [DW-1:0] w_a_edge [N];
  logic signed [DW-1:0] w_b_edge [N];
  logic signed [DW-1:0] w_a_sk   [N];
  logic signed [DW-1:0] w_b_sk   [N];

  logic signed [DW-1:0]        r_a   [N][N];
  logic signed [DW-1:0]        r_b   [N][N];
  logic signed [DW-1:0]        w_ain [N][N];
  logic signed [DW-1:0]        w_bin [N][N];
  logic signed [ACC_WIDTH-1:0] r_acc  [N][N];
  logic signed [ACC_WIDTH-1:0] w_nacc [N][N];

`ifdef SYSTOLIC_SATURATE_EN
  logic w_sat [N][N];
  logic w_any_sat;
  logic r_sat;
`endif

  assign w_go   = (r_state == S_IDLE) && start;
  assign w_clr  = w_go && !acc_mode;
  assign w_step = ((r_state == S_LOAD) && in_valid)
                || (r_state == S_DRAIN);

  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = (r_state == S_OUTPUT);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign out_idx   = r_idx;

  // Edges see zeros outside LOAD so DRAIN flushes the array.
  for (genvar i = 0; i < N; i++) begin : g_edge
    assign w_a_edge[i] = (r_state == S_LOAD)
                       ? a_vec[i*DW +: DW] : '0;
    assign w_b_edge[i] = (r_state == S_LOAD)
                       ? b_vec[i*DW +: DW] : '0;

    systolic_skew_sr #(
      .DEPTH (i),
      .WIDTH (DW)
    ) u_a_sk (
      .clock   (clock),
      .reset_n (reset_n),
      .shift   (w_step),
      .din     (w_a_edge[i]),
      .dout    (w_a_sk[i])
    );

    systolic_skew_sr #(
      .DEPTH (i),
      .WIDTH (DW)
    ) u_b_sk (
      .clock   (clock),
      .reset_n (reset_n),
      .shift   (w_step),
      .din     (w_b_edge[i]),
      .dout    (w_b_sk[i])
    );
  end

  for (genvar r = 0; r < N; r++) begin : g_r
    for (genvar c = 0; c < N; c++) begin : g_c
      logic signed [2*DW-1:0]      w_prod;
      logic signed [ACC_WIDTH-1:0] w_pext;

      if (c == 0) begin : g_ae
        assign w_ain[r][c] = w_a_sk[r];
      end else begin : g_ai
        assign w_ain[r][c] = r_a[r][c-1];
      end

      if (r == 0) begin : g_be
        assign w_bin[r][c] = w_b_sk[c];
      end else begin : g_bi
        assign w_bin[r][c] = r_b[r-1][c];
      end

      assign w_prod = (2*DW)'(w_ain[r][c])
                    * (2*DW)'(w_bin[r][c]);
      assign w_pext = ACC_WIDTH'(w_prod);

`ifdef SYSTOLIC_SATURATE_EN
      sat_res_t w_res;
      logic     w_unused_hi;
      assign w_res = sat_add(SAT_W'(r_acc[r][c]),
                             SAT_W'(w_pext), ACC_WIDTH);
      assign w_nacc[r][c] = w_res.val[ACC_WIDTH-1:0];
      assign w_sat[r][c]  = w_res.sat;
      assign w_unused_hi  = ^w_res.val[SAT_W-1:ACC_WIDTH];
`else
      assign w_nacc[r][c] = r_acc[r][c] + w_pext;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_a[r][c]   <= '0;
          r_b[r][c]   <= '0;
          r_acc[r][c] <= '0;
        end
      end
    end else if (w_clr) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) r_acc[r][c] <= '0;
      end
    end else if (w_step) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_a[r][c]   <= w_ain[r][c];
          r_b[r][c]   <= w_bin[r][c];
          r_acc[r][c] <= w_nacc[r][c];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_klen  <= '0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_klen  <= k_len;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_idx   <= '0;
            r_state <= (k_len == '0) ? S_OUTPUT : S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (r_cnt == r_klen - K_WIDTH'(1)) r_state <= S_DRAIN;
            r_cnt <= r_cnt + K_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DRAIN_LAST) r_state <= S_OUTPUT;
          r_dcnt <= r_dcnt + DC_W'(1);
        end
        S_OUTPUT: begin
          if (out_ready) begin
            if (r_idx == IDX_LAST) begin
              r_idx   <= '0;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_row = '0;
    for (int c = 0; c < N; c++) begin
      out_row[c*ACC_WIDTH +: ACC_WIDTH] = r_acc[r_idx][c];
    end
  end

`ifdef SYSTOLIC_SATURATE_EN
  always_comb begin
    w_any_sat = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) w_any_sat = w_any_sat | w_sat[r][c];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_sat <= 1'b0;
    else if (w_go) r_sat <= 1'b0;
    else if (w_step && w_any_sat) r_sat <= 1'b1;
  end

  assign sat_flag = r_sat;
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: job table, reference model and row scoreboard.
// Saturation expectations follow SYSTOLIC_SATURATE_EN.
`timescale 1ns/1ps
module tb_systolic_mm_engine;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KW = 10;

  logic              clock    = 1'b0;
  logic              reset_n  = 1'b0;
  logic              start    = 1'b0;
  logic [KW-1:0]     k_len    = '0;
  logic              acc_mode = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*DW-1:0]   a_vec    = '0;
  logic [N*DW-1:0]   b_vec    = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N*AW-1:0]   out_row;
  logic [1:0]        out_idx;
  logic              busy;
  logic              done;
  logic              sat_flag;

  always #5 clock = ~clock;

  systolic_mm_engine #(
    .N          (N),
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .K_WIDTH    (KW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .k_len     (k_len),
    .acc_mode  (acc_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .sat_flag  (sat_flag)
  );

  typedef struct packed {
    int     k;
    bit     accm;
    bit     ident;
    int     av;
    int     bv;
    bit     stall;
    int     hold_row;
    longint exp00;
  } vec_t;

  typedef struct packed {
    logic [1:0]      idx;
    logic [N*AW-1:0] row;
  } row_t;

  vec_t   vecs [6];
  row_t   q [$];
  longint mc [N][N];
  bit     msat;
  int     n_chk  = 0;
  int     n_fail = 0;

  task automatic check(input bit ok, input string name,
                       input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int a_el(input vec_t v, input int k, input int r);
    return v.ident ? ((r == k) ? 1 : 0) : v.av;
  endfunction

  function automatic int b_el(input vec_t v, input int k, input int c);
    return v.ident ? (k * N + c + 1) : v.bv;
  endfunction

  task automatic drive_beat(input vec_t v, input int k);
    for (int i = 0; i < N; i++) begin
      a_vec[i*DW +: DW] = 16'(a_el(v, k, i));
      b_vec[i*DW +: DW] = 16'(b_el(v, k, i));
    end
  endtask

  task automatic model_job(input vec_t v);
    longint s;
    row_t   rw;
    if (!v.accm) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) mc[r][c] = 0;
    end
    msat = 1'b0;
    for (int k = 0; k < v.k; k++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          s = mc[r][c] + longint'(a_el(v, k, r)) * longint'(b_el(v, k, c));
`ifdef SYSTOLIC_SATURATE_EN
          if (s > 64'sd2147483647) begin
            s = 64'sd2147483647;
            msat = 1'b1;
          end else if (s < -64'sd2147483648) begin
            s = -64'sd2147483648;
            msat = 1'b1;
          end
`else
          s = longint'(int'(s));
`endif
          mc[r][c] = s;
        end
      end
    end
    for (int r = 0; r < N; r++) begin
      rw.idx = 2'(r);
      for (int c = 0; c < N; c++) rw.row[c*AW +: AW] = 32'(mc[r][c]);
      q.push_back(rw);
    end
  endtask

  task automatic run_job(input vec_t v, input int id);
    int              beat;
    int              cyc;
    int              rows;
    int              hold;
    int              first;
    int              dn;
    longint          got00;
    logic [N*AW-1:0] held_row;
    logic [1:0]      held_idx;
    row_t            ex;
    @(negedge clock);
    start    = 1'b1;
    k_len    = KW'(v.k);
    acc_mode = v.accm;
    model_job(v);
    @(negedge clock);
    start    = 1'b0;
    k_len    = '0;
    acc_mode = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < v.k && cyc < 200) begin
      if (v.stall && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        drive_beat(v, beat);
      end
      start = v.ident && (cyc == 1);
      #1;
      check(in_ready == 1'b1, "in_ready_load", longint'(in_ready), 1);
      @(negedge clock);
      if (in_valid) beat++;
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (beat < v.k) check(1'b0, "load_timeout", beat, v.k);
    rows  = 0;
    cyc   = 0;
    hold  = 0;
    first = -1;
    got00 = 0;
    held_row = '0;
    held_idx = '0;
    while (rows < N && cyc < 200) begin
      @(negedge clock);
      cyc++;
      out_ready = 1'b0;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (int'(out_idx) == v.hold_row && hold < 5) begin
          if (hold == 0) begin
            held_row = out_row;
            held_idx = out_idx;
          end else begin
            check(out_row == held_row && out_idx == held_idx,
                  "hold_stable", longint'(out_idx), longint'(held_idx));
          end
          hold++;
        end else begin
          out_ready = 1'b1;
          if (rows == 0) got00 = longint'($signed(out_row[AW-1:0]));
          if (q.size() == 0) begin
            check(1'b0, "unexpected_row", longint'(out_idx), -1);
          end else begin
            ex = q.pop_front();
            n_chk++;
            if (out_idx != ex.idx || out_row != ex.row) begin
              n_fail++;
              $display("FAIL row job%0d: got idx %0d row %h, expected idx %0d row %h",
                       id, out_idx, out_row, ex.idx, ex.row);
            end
          end
          rows++;
        end
      end
    end
    if (rows < N) check(1'b0, "output_timeout", rows, N);
    check(first == ((v.k == 0) ? 1 : 2 * N - 2), "first_valid",
          first, (v.k == 0) ? 1 : 2 * N - 2);
    check(got00 == v.exp00, "c00", got00, v.exp00);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      out_ready = 1'b0;
      if (done) dn++;
    end
    check(dn == 1, "done_pulses", dn, 1);
    check(busy == 1'b0 && out_valid == 1'b0, "idle_after",
          longint'(busy), 0);
    check(sat_flag == msat, "sat_flag", longint'(sat_flag), longint'(msat));
  endtask

  task automatic reset_mid_load();
    @(negedge clock);
    start    = 1'b1;
    k_len    = KW'(4);
    acc_mode = 1'b0;
    @(negedge clock);
    start = 1'b0;
    k_len = '0;
    in_valid = 1'b1;
    drive_beat(vecs[4], 0);
    @(negedge clock);
    @(negedge clock);
    check(busy == 1'b1 && in_ready == 1'b1, "pre_reset_load",
          longint'(in_ready), 1);
    #2 reset_n = 1'b0;
    #1;
    check(busy == 1'b0, "rst_busy", longint'(busy), 0);
    check(in_ready == 1'b0, "rst_in_ready", longint'(in_ready), 0);
    check(out_valid == 1'b0, "rst_out_valid", longint'(out_valid), 0);
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mc[r][c] = 0;
    msat = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4, 1'b0, 1'b1, 0, 0, 1'b0, -1, 64'sd1};
    vecs[1] = '{3, 1'b0, 1'b0, 2, -3, 1'b1, -1, -64'sd18};
    vecs[2] = '{3, 1'b1, 1'b0, 2, -3, 1'b0, -1, -64'sd36};
    vecs[3] = '{0, 1'b0, 1'b0, 5, 7, 1'b0, -1, 64'sd0};
    vecs[4] = '{2, 1'b1, 1'b0, 1, 1, 1'b0, 2, 64'sd2};
`ifdef SYSTOLIC_SATURATE_EN
    vecs[5] = '{3, 1'b0, 1'b0, -32768, -32768, 1'b0, -1, 64'sd2147483647};
`else
    vecs[5] = '{3, 1'b0, 1'b0, -32768, -32768, 1'b0, -1, -64'sd1073741824};
`endif
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mc[r][c] = 0;
    msat = 1'b0;

    repeat (2) @(negedge clock);
    check(busy == 1'b0, "reset_busy", longint'(busy), 0);
    check(in_ready == 1'b0, "reset_in_ready", longint'(in_ready), 0);
    check(out_valid == 1'b0, "reset_out_valid", longint'(out_valid), 0);
    check(done == 1'b0, "reset_done", longint'(done), 0);
    check(sat_flag == 1'b0, "reset_sat", longint'(sat_flag), 0);
    check(out_idx == 2'd0, "reset_out_idx", longint'(out_idx), 0);
    check(out_row == '0, "reset_out_row", longint'(out_row[AW-1:0]), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (i == 4) reset_mid_load();
      run_job(vecs[i], i);
    end
    check(q.size() == 0, "scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
